// File: rtl/ibex_pmu_counter_mo_if.sv
// Counter-bus bundle: core-side pmc_* request/response plus the counter_* bus.
// master is the bus-master block's view; slave is the core/counter environment's view.
interface ibex_pmu_counter_mo_if #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32
);
   logic                 pmc_req_i;
   logic                 pmc_we_i;
   logic [AddrWidth-1:0] pmc_addr_i;
   logic [DataWidth-1:0] pmc_wdata_i;
   logic                 pmc_gnt_o;
   logic                 pmc_resp_valid_o;
   logic                 pmc_rdata_valid_o;
   logic [DataWidth-1:0] pmc_rdata_o;
   logic                 pmc_err_o;
   logic                 pmc_busy_o;
   logic                 pmc_spurious_o;
   logic                 counter_req_o;
   logic                 counter_gnt_i;
   logic                 counter_rvalid_i;
   logic                 counter_err_i;
   logic [AddrWidth-1:0] counter_addr_o;
   logic                 counter_we_o;
   logic [DataWidth-1:0] counter_wdata_o;
   logic [DataWidth-1:0] counter_rdata_i;

   modport master (
      input  pmc_req_i, pmc_we_i, pmc_addr_i, pmc_wdata_i,
      output pmc_gnt_o, pmc_resp_valid_o, pmc_rdata_valid_o, pmc_rdata_o,
      output pmc_err_o, pmc_busy_o, pmc_spurious_o,
      output counter_req_o, counter_addr_o, counter_we_o, counter_wdata_o,
      input  counter_gnt_i, counter_rvalid_i, counter_err_i, counter_rdata_i
   );

   modport slave (
      output pmc_req_i, pmc_we_i, pmc_addr_i, pmc_wdata_i,
      input  pmc_gnt_o, pmc_resp_valid_o, pmc_rdata_valid_o, pmc_rdata_o,
      input  pmc_err_o, pmc_busy_o, pmc_spurious_o,
      input  counter_req_o, counter_addr_o, counter_we_o, counter_wdata_o,
      output counter_gnt_i, counter_rvalid_i, counter_err_i, counter_rdata_i
   );
endinterface

// File: rtl/ibex_pmu_counter_mo.sv
// Performance-counter bus master with up to MaxOutstanding in-flight accesses and an optional
// response timeout. Request/grant and rvalid/response are both zero-latency; a full pending FIFO blocks new requests.
module ibex_pmu_counter_mo #(
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned TimeoutCycles  = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   ibex_pmu_counter_mo_if.master bus
);
   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned TmrW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
   localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);
   localparam logic [TmrW-1:0] TmrLast = TmrW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
   localparam logic            TmoEn   = (TimeoutCycles > 0);

   typedef enum logic {IDLE, HOLD} state_e;

   state_e                    state_q;
   logic                      rst_q;
   logic [AddrWidth-1:0]      hold_addr_q;
   logic                      hold_we_q;
   logic [DataWidth-1:0]      hold_wdata_q;
   logic [MaxOutstanding-1:0] fifo_we_q;
   logic [PtrW-1:0]           wr_ptr_q;
   logic [PtrW-1:0]           rd_ptr_q;
   logic [CntW-1:0]           cnt_q;
   logic [CntW-1:0]           drop_q;
   logic [TmrW-1:0]           tmr_q;
   logic                      spurious_q;

   logic live, empty, full, held, req, gnt, we_sel, we_head;
   logic drop_hit, rsp_pop, spurious_hit, timeout, pop;

   // Outputs stay quiet during reset and for one cycle after release.
   assign live  = ~rst_i & ~rst_q;
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CntMax);
   assign held  = (state_q == HOLD);

   assign req     = live & ~full & (held | bus.pmc_req_i);
   assign gnt     = req & bus.counter_gnt_i;
   assign we_sel  = held ? hold_we_q : bus.pmc_we_i;
   assign we_head = fifo_we_q[rd_ptr_q];

   // Late responses of timed-out transactions are swallowed before anything else.
   assign drop_hit     = live & bus.counter_rvalid_i & (drop_q != '0);
   assign rsp_pop      = live & bus.counter_rvalid_i & (drop_q == '0) & ~empty;
   assign spurious_hit = bus.counter_rvalid_i & (drop_q == '0) & empty;
   assign timeout      = TmoEn & live & ~bus.counter_rvalid_i & ~empty & (tmr_q == TmrLast);
   assign pop          = rsp_pop | timeout;

   assign bus.pmc_gnt_o         = gnt;
   assign bus.counter_req_o     = req;
   assign bus.counter_addr_o    = req ? (held ? hold_addr_q : bus.pmc_addr_i) : '0;
   assign bus.counter_we_o      = req & we_sel;
   assign bus.counter_wdata_o   = req ? (held ? hold_wdata_q : bus.pmc_wdata_i) : '0;
   assign bus.pmc_resp_valid_o  = pop;
   assign bus.pmc_err_o         = rsp_pop ? bus.counter_err_i : timeout;
   assign bus.pmc_rdata_valid_o = rsp_pop & ~we_head & ~bus.counter_err_i;
   assign bus.pmc_rdata_o       = rsp_pop ? bus.counter_rdata_i : '0;
   assign bus.pmc_busy_o        = live & (~empty | held);
   assign bus.pmc_spurious_o    = live & spurious_q;

   always_ff @(posedge clk_i) begin
      rst_q <= rst_i;
      if (rst_i) begin
         state_q      <= IDLE;
         hold_addr_q  <= '0;
         hold_we_q    <= 1'b0;
         hold_wdata_q <= '0;
         fifo_we_q    <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         drop_q       <= '0;
         tmr_q        <= '0;
         spurious_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req && !bus.counter_gnt_i) begin
                  state_q      <= HOLD;
                  hold_addr_q  <= bus.pmc_addr_i;
                  hold_we_q    <= bus.pmc_we_i;
                  hold_wdata_q <= bus.pmc_wdata_i;
               end
            end
            HOLD: begin
               if (gnt) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase

         if (gnt) begin
            fifo_we_q[wr_ptr_q] <= we_sel;
            wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;

         if (gnt && !pop)      cnt_q <= cnt_q + 1'b1;
         else if (!gnt && pop) cnt_q <= cnt_q - 1'b1;

         if (drop_hit)                         drop_q <= drop_q - 1'b1;
         else if (timeout && drop_q != CntMax) drop_q <= drop_q + 1'b1;

         if (!TmoEn || pop || drop_hit || empty) tmr_q <= '0;
         else                                     tmr_q <= tmr_q + 1'b1;

         if (spurious_hit) spurious_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_ibex_pmu_counter_mo.sv
// Bench for ibex_pmu_counter_mo: cycle table, hand-written timeout/reset sequences,
// then random traffic against a queue-based reference model.
module tb_ibex_pmu_counter_mo;
   localparam int MaxOut = 2;
   localparam int Tmo    = 8;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   ibex_pmu_counter_mo_if #(.AddrWidth(32), .DataWidth(32)) bus ();

   ibex_pmu_counter_mo #(
      .AddrWidth(32), .DataWidth(32), .MaxOutstanding(MaxOut), .TimeoutCycles(Tmo)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   typedef struct {
      logic req; logic we; logic [31:0] addr; logic [31:0] wdata;
      logic gnt; logic rv; logic err; logic [31:0] rdata;
      logic e_pgnt; logic e_creq; logic [31:0] e_caddr; logic e_cwe; logic [31:0] e_cwdata;
      logic e_rvld; logic e_rdv; logic e_err; logic [31:0] e_rdata; logic e_busy;
   } vec_t;

   vec_t vecs[22];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic gnt, input logic rv,
                        input logic err, input logic [31:0] rdata);
      bus.pmc_req_i = req;  bus.pmc_we_i = we;  bus.pmc_addr_i = addr;  bus.pmc_wdata_i = wdata;
      bus.counter_gnt_i = gnt;  bus.counter_rvalid_i = rv;  bus.counter_err_i = err;
      bus.counter_rdata_i = rdata;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic cyc_end();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_flags"}, {24'h0, bus.pmc_gnt_o, bus.counter_req_o, bus.pmc_resp_valid_o,
          bus.pmc_rdata_valid_o, bus.pmc_err_o, bus.pmc_busy_o, bus.pmc_spurious_o,
          bus.counter_we_o}, 32'h0);
      chk({tag, "_caddr"}, bus.counter_addr_o, 32'h0);
      chk({tag, "_cwdata"}, bus.counter_wdata_o, 32'h0);
      chk({tag, "_rdata"}, bus.pmc_rdata_o, 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bit          pend[$];
      bit          held, h_we, spur;
      logic [31:0] h_addr, h_wdata;
      int          drop, waitc;

      //           req  we    addr         wdata        gnt   rv    err   rdata        | pgnt creq caddr        cwe   cwdata       rvld  rdv   err   rdata        busy
      vecs[0]  = '{1'b1,1'b0,32'h100,     32'h0,       1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h100,     1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b0};
      vecs[1]  = '{1'b0,1'b0,32'h0,       32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b1};
      vecs[2]  = '{1'b0,1'b0,32'h0,       32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b1};
      vecs[3]  = '{1'b0,1'b0,32'h0,       32'h0,       1'b0,1'b1,1'b0,32'hDEADBEEF, 1'b0,1'b0,32'h0,       1'b0,32'h0,       1'b1,1'b1,1'b0,32'hDEADBEEF, 1'b1};
      vecs[4]  = '{1'b0,1'b0,32'h0,       32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b0};
      vecs[5]  = '{1'b1,1'b1,32'h200,     32'h11111111,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h200,     1'b1,32'h11111111,1'b0,1'b0,1'b0,32'h0,        1'b0};
      vecs[6]  = '{1'b1,1'b0,32'h300,     32'h22222222,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h200,     1'b1,32'h11111111,1'b0,1'b0,1'b0,32'h0,        1'b1};
      vecs[7]  = '{1'b1,1'b1,32'h400,     32'h33333333,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h200,     1'b1,32'h11111111,1'b0,1'b0,1'b0,32'h0,        1'b1};
      vecs[8]  = '{1'b1,1'b0,32'h500,     32'h44444444,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h200,     1'b1,32'h11111111,1'b0,1'b0,1'b0,32'h0,        1'b1};
      vecs[9]  = '{1'b1,1'b0,32'h600,     32'h55555555,1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h200,     1'b1,32'h11111111,1'b0,1'b0,1'b0,32'h0,        1'b1};
      vecs[10] = '{1'b0,1'b0,32'h0,       32'h0,       1'b0,1'b1,1'b0,32'hAAAAAAAA, 1'b0,1'b0,32'h0,       1'b0,32'h0,       1'b1,1'b0,1'b0,32'h0,        1'b1};
      vecs[11] = '{1'b0,1'b0,32'h0,       32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b0};
      vecs[12] = '{1'b1,1'b0,32'h10,      32'h0,       1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h10,      1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b0};
      vecs[13] = '{1'b1,1'b1,32'h14,      32'h55,      1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h14,      1'b1,32'h55,      1'b0,1'b0,1'b0,32'h0,        1'b1};
      vecs[14] = '{1'b1,1'b0,32'h18,      32'h0,       1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b1};
      vecs[15] = '{1'b1,1'b0,32'h18,      32'h0,       1'b1,1'b1,1'b0,32'hA0,       1'b0,1'b0,32'h0,       1'b0,32'h0,       1'b1,1'b1,1'b0,32'hA0,       1'b1};
      vecs[16] = '{1'b1,1'b0,32'h18,      32'h0,       1'b1,1'b1,1'b0,32'hB0,       1'b1,1'b1,32'h18,      1'b0,32'h0,       1'b1,1'b0,1'b0,32'h0,        1'b1};
      vecs[17] = '{1'b0,1'b0,32'h0,       32'h0,       1'b0,1'b1,1'b0,32'hC0,       1'b0,1'b0,32'h0,       1'b0,32'h0,       1'b1,1'b1,1'b0,32'hC0,       1'b1};
      vecs[18] = '{1'b0,1'b0,32'h0,       32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b0};
      vecs[19] = '{1'b1,1'b0,32'h20,      32'h0,       1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h20,      1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b0};
      vecs[20] = '{1'b0,1'b0,32'h0,       32'h0,       1'b0,1'b1,1'b1,32'h1234,     1'b0,1'b0,32'h0,       1'b0,32'h0,       1'b1,1'b0,1'b1,32'h0,        1'b1};
      vecs[21] = '{1'b0,1'b0,32'h0,       32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,       1'b0,32'h0,       1'b0,1'b0,1'b0,32'h0,        1'b0};

      // Reset: quiet while asserted and on the first cycle after release.
      rst = 1'b1;
      drive(1'b1, 1'b1, 32'h5, 32'h6, 1'b1, 1'b0, 1'b0, 32'h7);
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk_zero("rst_hi");
      cyc_end();
      rst = 1'b0;
      @(negedge clk);
      chk_zero("rst_rel");
      cyc_end();
      idle();

      foreach (vecs[i]) begin
         vec_t v;
         v = vecs[i];
         drive(v.req, v.we, v.addr, v.wdata, v.gnt, v.rv, v.err, v.rdata);
         @(negedge clk);
         chk($sformatf("vec%0d_pgnt", i), bus.pmc_gnt_o, v.e_pgnt);
         chk($sformatf("vec%0d_creq", i), bus.counter_req_o, v.e_creq);
         chk($sformatf("vec%0d_rvld", i), bus.pmc_resp_valid_o, v.e_rvld);
         chk($sformatf("vec%0d_rdv", i), bus.pmc_rdata_valid_o, v.e_rdv);
         chk($sformatf("vec%0d_err", i), bus.pmc_err_o, v.e_err);
         chk($sformatf("vec%0d_busy", i), bus.pmc_busy_o, v.e_busy);
         if (v.e_creq) begin
            chk($sformatf("vec%0d_caddr", i), bus.counter_addr_o, v.e_caddr);
            chk($sformatf("vec%0d_cwe", i), bus.counter_we_o, v.e_cwe);
            chk($sformatf("vec%0d_cwdata", i), bus.counter_wdata_o, v.e_cwdata);
         end
         if (v.e_rdv) chk($sformatf("vec%0d_rdata", i), bus.pmc_rdata_o, v.e_rdata);
         cyc_end();
      end
      idle();

      // Timeout after Tmo cycles, late response swallowed, then a normal read.
      drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("t5_gnt", bus.pmc_gnt_o, 1'b1);
      cyc_end();
      idle();
      for (int k = 1; k < Tmo; k++) begin
         @(negedge clk);
         chk($sformatf("t5_wait%0d", k), bus.pmc_resp_valid_o, 1'b0);
         cyc_end();
      end
      @(negedge clk);
      chk("t5_tmo_rvld", bus.pmc_resp_valid_o, 1'b1);
      chk("t5_tmo_err", bus.pmc_err_o, 1'b1);
      chk("t5_tmo_rdv", bus.pmc_rdata_valid_o, 1'b0);
      cyc_end();
      @(negedge clk);
      chk("t5_busy_after", bus.pmc_busy_o, 1'b0);
      cyc_end();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h999);
      @(negedge clk);
      chk("t5_late_rvld", bus.pmc_resp_valid_o, 1'b0);
      cyc_end();
      idle();
      @(negedge clk);
      chk("t5_late_spur", bus.pmc_spurious_o, 1'b0);
      cyc_end();
      drive(1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("t5_next_gnt", bus.pmc_gnt_o, 1'b1);
      cyc_end();
      idle();
      cyc_end();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h600DF00D);
      @(negedge clk);
      chk("t5_next_rvld", bus.pmc_resp_valid_o, 1'b1);
      chk("t5_next_rdv", bus.pmc_rdata_valid_o, 1'b1);
      chk("t5_next_err", bus.pmc_err_o, 1'b0);
      chk("t5_next_rdata", bus.pmc_rdata_o, 32'h600DF00D);
      cyc_end();
      idle();

      // Spurious response is sticky; reset in HOLD clears it and returns to IDLE.
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1);
      @(negedge clk);
      chk("t6_spur_rvld", bus.pmc_resp_valid_o, 1'b0);
      chk("t6_spur_pre", bus.pmc_spurious_o, 1'b0);
      cyc_end();
      idle();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("t6_spur_sticky%0d", k), bus.pmc_spurious_o, 1'b1);
         cyc_end();
      end
      drive(1'b1, 1'b1, 32'h77, 32'h88, 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("t6_hold_req", bus.counter_req_o, 1'b1);
      cyc_end();
      @(negedge clk);
      chk("t6_hold_busy", bus.pmc_busy_o, 1'b1);
      cyc_end();
      rst = 1'b1;
      @(negedge clk);
      chk_zero("t6_rst_hi");
      cyc_end();
      rst = 1'b0;
      @(negedge clk);
      chk_zero("t6_rst_rel");
      cyc_end();
      drive(1'b1, 1'b0, 32'h99, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("t6_idle_caddr", bus.counter_addr_o, 32'h99);
      chk("t6_idle_pgnt", bus.pmc_gnt_o, 1'b1);
      chk("t6_idle_busy", bus.pmc_busy_o, 1'b0);
      chk("t6_idle_spur", bus.pmc_spurious_o, 1'b0);
      cyc_end();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h5A5A);
      @(negedge clk);
      chk("t6_pop_rvld", bus.pmc_resp_valid_o, 1'b1);
      chk("t6_pop_rdata", bus.pmc_rdata_o, 32'h5A5A);
      cyc_end();
      idle();

      // Random traffic against the reference model.
      held = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
      spur = 1'b0; drop = 0; waitc = 0;
      for (int c = 0; c < 600; c++) begin
         logic        r_req, r_we, r_gnt, r_rv, r_err;
         logic [31:0] r_addr, r_wdata, r_rdata;
         bit          full, e_creq, e_pgnt, e_busy, sw, pp, sp, tmo, e_rvld, e_err, e_rdv;
         int          new_wait;
         r_req   = ($urandom_range(0, 99) < 50);
         r_we    = 1'($urandom_range(0, 1));
         r_gnt   = ($urandom_range(0, 99) < 60);
         r_rv    = ($urandom_range(0, 99) < 30);
         r_err   = ($urandom_range(0, 99) < 20);
         r_addr  = $urandom;
         r_wdata = $urandom;
         r_rdata = $urandom;
         drive(r_req, r_we, r_addr, r_wdata, r_gnt, r_rv, r_err, r_rdata);

         full   = (pend.size() == MaxOut);
         e_creq = !full && (held || r_req);
         e_pgnt = e_creq && r_gnt;
         e_busy = (pend.size() != 0) || held;
         sw     = r_rv && (drop > 0);
         pp     = r_rv && (drop == 0) && (pend.size() > 0);
         sp     = r_rv && (drop == 0) && (pend.size() == 0);
         tmo    = !r_rv && (pend.size() > 0) && (waitc + 1 >= Tmo);
         e_rvld = pp || tmo;
         e_err  = pp ? r_err : tmo;
         e_rdv  = pp && !pend[0] && !r_err;

         @(negedge clk);
         chk($sformatf("rnd%0d_creq", c), bus.counter_req_o, e_creq);
         chk($sformatf("rnd%0d_pgnt", c), bus.pmc_gnt_o, e_pgnt);
         chk($sformatf("rnd%0d_rvld", c), bus.pmc_resp_valid_o, e_rvld);
         chk($sformatf("rnd%0d_err", c), bus.pmc_err_o, e_err);
         chk($sformatf("rnd%0d_rdv", c), bus.pmc_rdata_valid_o, e_rdv);
         chk($sformatf("rnd%0d_busy", c), bus.pmc_busy_o, e_busy);
         chk($sformatf("rnd%0d_spur", c), bus.pmc_spurious_o, spur);
         if (e_creq) begin
            chk($sformatf("rnd%0d_caddr", c), bus.counter_addr_o, held ? h_addr : r_addr);
            chk($sformatf("rnd%0d_cwe", c), bus.counter_we_o, held ? h_we : r_we);
            chk($sformatf("rnd%0d_cwdata", c), bus.counter_wdata_o, held ? h_wdata : r_wdata);
         end
         if (e_rdv) chk($sformatf("rnd%0d_rdata", c), bus.pmc_rdata_o, r_rdata);

         new_wait = (pp || sw || tmo || pend.size() == 0) ? 0 : waitc + 1;
         if (pp || tmo) void'(pend.pop_front());
         if (tmo && drop < MaxOut) drop++;
         if (sw) drop--;
         if (sp) spur = 1'b1;
         if (e_pgnt) pend.push_back(held ? h_we : r_we);
         if (held && e_pgnt) held = 1'b0;
         else if (!held && e_creq && !r_gnt) begin
            held = 1'b1; h_addr = r_addr; h_we = r_we; h_wdata = r_wdata;
         end
         waitc = new_wait;
         cyc_end();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
